// File: rtl/trace_vector_writer.sv
// ============================================================================
// trace_vector_writer: captures {a, b, y} tuples into a buffer, then drains
// them as MSB-first packed words over a valid/ready stream.
// Revision: 1.0
// ============================================================================
`default_nettype none

module trace_vector_writer #(
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = 8,
  parameter int DEPTH     = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              stop,
  input  logic                              cap_valid,
  input  logic [WIDTH_IN-1:0]               cap_a,
  input  logic [WIDTH_IN-1:0]               cap_b,
  input  logic [WIDTH_OUT-1:0]              cap_y,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [2*WIDTH_IN+WIDTH_OUT-1:0]   out_data,
  output logic                              out_last,
  output logic [$clog2(DEPTH):0]            count,
  output logic                              busy,
  output logic                              overflow
);

  localparam int VEC_W = 2*WIDTH_IN + WIDTH_OUT;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            overflow_q, overflow_d;
  logic            wr_en;
  logic            last;

  logic [VEC_W-1:0] mem_q [DEPTH];

  // count doubles as the write pointer: it never wraps within a run.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[count_q[AW-1:0]] <= {cap_a, cap_b, cap_y};
    end
  end

  assign last = (state_q == DRAIN) && ({1'b0, rd_ptr_q} == (count_q - CW'(1)));

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = CAPTURE;
          count_d    = '0;
          overflow_d = 1'b0;
        end
      end
      CAPTURE: begin
        if (cap_valid) begin
          wr_en   = 1'b1;
          count_d = count_q + CW'(1);
        end
        if (count_d == CW'(DEPTH)) begin
          state_d  = DRAIN;
          rd_ptr_d = '0;
        end else if (stop) begin
          state_d  = (count_d == '0) ? IDLE : DRAIN;
          rd_ptr_d = '0;
        end
      end
      DRAIN: begin
        if (cap_valid) begin
          overflow_d = 1'b1;
        end
        if (out_ready) begin
          if (last) begin
            state_d = IDLE;
          end else begin
            rd_ptr_d = rd_ptr_q + AW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DRAIN);
  assign out_last  = last;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_trace_vector_writer.sv
// Directed-vector bench for trace_vector_writer with hand-computed expectations.
`default_nettype none

module tb_trace_vector_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stop, cap_valid, out_ready;
  logic [7:0]  cap_a, cap_b, cap_y;
  logic        out_valid, out_last, busy, overflow;
  logic [23:0] out_data;
  logic [4:0]  count;

  int n_checks = 0;
  int n_pass   = 0;

  trace_vector_writer #(.WIDTH_IN(8), .WIDTH_OUT(8), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .cap_valid(cap_valid), .cap_a(cap_a), .cap_b(cap_b), .cap_y(cap_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .count(count), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic cap(input logic [7:0] a, input logic [7:0] b, input logic [7:0] y, input logic s);
    cap_valid = 1'b1; cap_a = a; cap_b = b; cap_y = y; stop = s;
    tick();
    cap_valid = 1'b0; stop = 1'b0;
  endtask

  logic [23:0] exp3 [3];

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; cap_valid = 1'b0; out_ready = 1'b0;
    cap_a = '0; cap_b = '0; cap_y = '0;
    tick(); tick();
    reset = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);

    // Full buffer, continuous drain; start during CAPTURE and start/stop during DRAIN ignored.
    do_start();
    check("full_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 16; i++) begin
      start = (i == 5);
      cap(8'(i), 8'(i + 1), 8'(i - (i + 1)), 1'b0);
      start = 1'b0;
      check("full_count", 32'(count), 32'(i + 1));
    end
    check("full_valid_entry", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      stop  = (k == 3);
      start = (k == 3);
      check("full_valid", 32'(out_valid), 32'd1);
      check("full_data", 32'(out_data), 32'({8'(k), 8'(k + 1), 8'hFF}));
      check("full_last", 32'(out_last), 32'(k == 15));
      check("full_cnt_drain", 32'(count), 32'd16);
      tick();
      stop = 1'b0; start = 1'b0;
    end
    check("full_ovf", 32'(overflow), 32'd0);
    check("full_idle_busy", 32'(busy), 32'd0);
    check("full_idle_valid", 32'(out_valid), 32'd0);
    check("full_idle_data", 32'(out_data), 32'd0);
    out_ready = 1'b0;

    // Early stop with backpressure toggling.
    tick();
    do_start();
    for (int i = 0; i < 3; i++) begin
      exp3[i] = {8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i)};
      cap(8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i), 1'b0);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    check("bp_count", 32'(count), 32'd3);
    begin
      int k;
      int c;
      k = 0;
      c = 0;
      while (k < 3 && c < 20) begin
        out_ready = c[0];
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_data", 32'(out_data), 32'(exp3[k]));
        check("bp_last", 32'(out_last), 32'(k == 2));
        tick();
        if (out_ready) k++;
        c++;
      end
      check("bp_words", 32'(k), 32'd3);
      check("bp_cycles", 32'(c), 32'd6);
    end
    out_ready = 1'b0;
    check("bp_idle_busy", 32'(busy), 32'd0);
    check("bp_idle_valid", 32'(out_valid), 32'd0);
    check("bp_count_persist", 32'(count), 32'd3);

    // Stop coincident with the last tuple.
    tick();
    do_start();
    cap(8'h01, 8'h02, 8'h03, 1'b0);
    cap(8'hAA, 8'h55, 8'h55, 1'b1);
    check("coin_count", 32'(count), 32'd2);
    check("coin_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    check("coin_w0", 32'(out_data), 32'h010203);
    check("coin_l0", 32'(out_last), 32'd0);
    tick();
    check("coin_w1", 32'(out_data), 32'hAA5555);
    check("coin_l1", 32'(out_last), 32'd1);
    tick();
    out_ready = 1'b0;
    check("coin_idle", 32'(busy), 32'd0);

    // Empty stop.
    tick();
    do_start();
    stop = 1'b1; tick(); stop = 1'b0;
    check("empty_busy", 32'(busy), 32'd0);
    check("empty_valid", 32'(out_valid), 32'd0);
    check("empty_count", 32'(count), 32'd0);

    // Overflow: cap_valid held during DRAIN.
    tick();
    do_start();
    for (int i = 0; i < 16; i++) cap(8'(i), 8'(i ^ 8'h5A), 8'(i * 3), 1'b0);
    cap_valid = 1'b1; cap_a = 8'hEE; cap_b = 8'hEE; cap_y = 8'hEE;
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check("ovf_data", 32'(out_data), 32'({8'(k), 8'(k ^ 8'h5A), 8'(k * 3)}));
      check("ovf_last", 32'(out_last), 32'(k == 15));
      tick();
    end
    cap_valid = 1'b0; out_ready = 1'b0;
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd16);
    check("ovf_idle", 32'(busy), 32'd0);
    tick();
    check("ovf_sticky", 32'(overflow), 32'd1);
    do_start();
    check("ovf_cleared", 32'(overflow), 32'd0);
    check("ovf_cnt_clr", 32'(count), 32'd0);
    stop = 1'b1; tick(); stop = 1'b0;

    // Reset mid-run, then a normal run.
    tick();
    do_start();
    cap(8'h11, 8'h22, 8'h33, 1'b0);
    cap(8'h44, 8'h55, 8'h66, 1'b0);
    cap(8'h77, 8'h88, 8'h99, 1'b0);
    reset = 1'b0; tick(); reset = 1'b1;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_count", 32'(count), 32'd0);
    do_start();
    cap(8'hC3, 8'h3C, 8'h87, 1'b1);
    check("mrst_rerun_cnt", 32'(count), 32'd1);
    check("mrst_rerun_data", 32'(out_data), 32'hC33C87);
    check("mrst_rerun_last", 32'(out_last), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("mrst_rerun_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
